// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: memory op codes, sequencer states and reset level shared by
// the MEM-stage load/store unit and its lane aligner.
package mem_access_unit_pkg;
  localparam logic RST_ACTIVE = 1'b0;
  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_e;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RD_WAIT,
    ST_WR_DATA,
    ST_DONE
  } state_e;
  function automatic logic op_valid(input logic [3:0] op);
    return op >= MEM_OP_LB && op <= MEM_OP_SW;
  endfunction
  function automatic logic op_store(input logic [3:0] op);
    return op >= MEM_OP_SB && op <= MEM_OP_SW;
  endfunction
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] a);
    return ((op == MEM_OP_LH || op == MEM_OP_LHU || op == MEM_OP_SH) && a[0]) ||
           ((op == MEM_OP_LW || op == MEM_OP_SW) && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: big-endian byte/halfword extraction for loads and lane merge for
// read-modify-write stores on a word-only RAM.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);
  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    bsh = {~lane_i, 3'b000};
    hsh = {~lane_i[1], 4'b0000};
    b = 8'(old_i >> bsh);
    h = 16'(old_i >> hsh);
    load_o = op_i == MEM_OP_LB  ? {{24{b[7]}}, b} :
             op_i == MEM_OP_LBU ? {24'b0, b} :
             op_i == MEM_OP_LH  ? {{16{h[15]}}, h} :
             op_i == MEM_OP_LHU ? {16'b0, h} :
             op_i == MEM_OP_LW  ? old_i : '0;
    store_o = op_i == MEM_OP_SB ? (old_i & ~(32'h0000_00FF << bsh)) | ({24'b0, wdata_i[7:0]} << bsh) :
              op_i == MEM_OP_SH ? (old_i & ~(32'h0000_FFFF << hsh)) | ({16'b0, wdata_i[15:0]} << hsh) :
              op_i == MEM_OP_SW ? wdata_i : old_i;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer in front of a word-only data RAM;
// stalls the pipeline per access and reports misalignment exceptions.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              exc_adel_o,
  output logic              exc_ades_o,
  output logic [ADDR_W-1:0] bad_addr_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic              ram_ack_i
);
  state_e            state_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              adel_q;
  logic              ades_q;
  logic [ADDR_W-1:0] bad_q;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] store_val;
  logic              req_ok;
  mem_lane_align u_align (
    .op_i    (op_q),
    .lane_i  (addr_q[1:0]),
    .old_i   (ram_data_i),
    .wdata_i (wdata_q),
    .load_o  (load_val),
    .store_o (store_val)
  );
  assign req_ok     = req_i && op_valid(op_i);
  assign stall_o    = state_q == ST_IDLE ? req_ok : state_q != ST_DONE;
  assign done_o     = state_q == ST_DONE;
  assign ram_ce_o   = state_q == ST_ISSUE || state_q == ST_WR_DATA;
  assign ram_we_o   = ram_ce_o && op_store(op_q);
  assign ram_addr_o = ram_ce_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  // Merge uses the old word the RAM returns for the ISSUE read, so it is only meaningful in WR_DATA.
  assign ram_data_o = state_q == ST_WR_DATA ? store_val : '0;
  assign rdata_o    = rdata_q;
  assign exc_adel_o = adel_q;
  assign exc_ades_o = ades_q;
  assign bad_addr_o = bad_q;
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
      bad_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_ok) begin
          op_q    <= op_i;
          addr_q  <= addr_i;
          wdata_q <= wdata_i;
          if (op_misaligned(op_i, addr_i[1:0])) begin
            adel_q  <= !op_store(op_i);
            ades_q  <= op_store(op_i);
            bad_q   <= addr_i;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE:   state_q <= op_store(op_q) ? ST_WR_DATA : ST_RD_WAIT;
        ST_RD_WAIT: begin
          rdata_q <= load_val;
          state_q <= ST_DONE;
        end
        ST_WR_DATA: if (ram_ack_i) state_q <= ST_DONE;
        ST_DONE: begin
          rdata_q <= '0;
          adel_q  <= 1'b0;
          ades_q  <= 1'b0;
          bad_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table, hand sequences for hold/reset corners, and
// random ops checked against a byte-array memory model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        stall_o, done_o, exc_adel_o, exc_ades_o, ram_ce_o, ram_we_o, ram_ack_i;
  logic [31:0] rdata_o, bad_addr_o, ram_addr_o, ram_data_o, ram_data_i;
  logic [31:0] mem [64] = '{default: 32'h0};
  logic [31:0] ref_mem [64];
  int          wcnt;
  int          hold_req = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .exc_adel_o(exc_adel_o),
    .exc_ades_o(exc_ades_o), .bad_addr_o(bad_addr_o), .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .ram_ack_i(ram_ack_i)
  );

  // RAM model: registered read, ack only from the second consecutive write cycle plus hold_req.
  assign ram_ack_i = ram_ce_o && ram_we_o && wcnt >= 1 + hold_req;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_data_i <= 32'h0;
      wcnt <= 0;
    end else begin
      if (ram_ce_o) ram_data_i <= mem[ram_addr_o[7:2]];
      wcnt <= (ram_ce_o && ram_we_o) ? wcnt + 1 : 0;
      if (ram_ack_i) mem[ram_addr_o[7:2]] <= ram_data_o;
    end
  end

  function automatic logic is_st(input logic [3:0] op);
    return op == MEM_OP_SB || op == MEM_OP_SH || op == MEM_OP_SW;
  endfunction

  function automatic logic m_mis(input logic [3:0] op, input logic [31:0] a);
    if (op == MEM_OP_LH || op == MEM_OP_LHU || op == MEM_OP_SH) return a % 2 != 0;
    if (op == MEM_OP_LW || op == MEM_OP_SW) return a % 4 != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] w, input logic [31:0] a);
    logic [7:0] b [4];
    int k;
    k = a % 4;
    for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
    case (op)
      MEM_OP_LB:  return {{24{b[k][7]}}, b[k]};
      MEM_OP_LBU: return {24'h0, b[k]};
      MEM_OP_LH:  return {{16{b[k][7]}}, b[k], b[k+1]};
      MEM_OP_LHU: return {16'h0, b[k], b[k+1]};
      MEM_OP_LW:  return w;
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [3:0] op, input logic [31:0] w, input logic [31:0] a, input logic [31:0] wd);
    logic [7:0] b [4];
    int k;
    k = a % 4;
    for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
    if (op == MEM_OP_SW) return wd;
    if (op == MEM_OP_SB) b[k] = wd[7:0];
    if (op == MEM_OP_SH) begin
      b[k] = wd[15:8];
      b[k+1] = wd[7:0];
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output int lat, output logic [31:0] rd, output logic [31:0] wr, output logic [31:0] bad,
                        output logic adel, output logic ades, output logic saw_ce, output logic stall_ok,
                        output logic stable, output logic idle_clr);
    logic [31:0] first;
    logic have;
    hold_req = hold;
    req_i = 1'b1; op_i = op; addr_i = a; wdata_i = wd;
    #1;
    stall_ok = stall_o; saw_ce = ram_ce_o; stable = 1'b1; have = 1'b0; wr = 32'h0; first = 32'h0;
    @(negedge clk);
    req_i = 1'b0; op_i = 4'd0;
    lat = 1;
    while (!done_o && lat < 20) begin
      saw_ce |= ram_ce_o;
      stall_ok &= stall_o;
      if (ram_we_o && wcnt >= 1) begin
        if (have && ram_data_o !== first) stable = 1'b0;
        first = ram_data_o;
        have = 1'b1;
      end
      if (ram_ack_i) wr = ram_data_o;
      @(negedge clk);
      lat++;
    end
    rd = rdata_o; adel = exc_adel_o; ades = exc_ades_o; bad = bad_addr_o;
    stall_ok &= !stall_o && !ram_ce_o && !ram_we_o;
    @(negedge clk);
    idle_clr = !done_o && rdata_o == 32'h0 && !exc_adel_o && !exc_ades_o && bad_addr_o == 32'h0;
    hold_req = 0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic [31:0] exp_wr;
    logic        exp_adel;
    logic        exp_ades;
  } vec_t;

  initial begin
    vec_t tbl [17];
    int lat;
    logic [31:0] rd, wr, bad, exp_rd;
    logic adel, ades, saw_ce, stall_ok, stable, idle_clr, mis, st;
    logic [7:0] done_seen;
    int bad_words;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    tbl[0]  = '{MEM_OP_SW,  32'h10, 32'h11223344, 0, 32'h0,        3, 32'h11223344, 1'b0, 1'b0};
    tbl[1]  = '{MEM_OP_SW,  32'h20, 32'h80FF0000, 0, 32'h0,        3, 32'h80FF0000, 1'b0, 1'b0};
    tbl[2]  = '{MEM_OP_LW,  32'h10, 32'h0,        0, 32'h11223344, 3, 32'h0,        1'b0, 1'b0};
    tbl[3]  = '{MEM_OP_LB,  32'h13, 32'h0,        0, 32'h00000044, 3, 32'h0,        1'b0, 1'b0};
    tbl[4]  = '{MEM_OP_LB,  32'h20, 32'h0,        0, 32'hFFFFFF80, 3, 32'h0,        1'b0, 1'b0};
    tbl[5]  = '{MEM_OP_LBU, 32'h20, 32'h0,        0, 32'h00000080, 3, 32'h0,        1'b0, 1'b0};
    tbl[6]  = '{MEM_OP_LH,  32'h20, 32'h0,        0, 32'hFFFF80FF, 3, 32'h0,        1'b0, 1'b0};
    tbl[7]  = '{MEM_OP_LHU, 32'h10, 32'h0,        0, 32'h00001122, 3, 32'h0,        1'b0, 1'b0};
    tbl[8]  = '{MEM_OP_LH,  32'h12, 32'h0,        0, 32'h00003344, 3, 32'h0,        1'b0, 1'b0};
    tbl[9]  = '{MEM_OP_SB,  32'h11, 32'h123456AB, 0, 32'h0,        3, 32'h11AB3344, 1'b0, 1'b0};
    tbl[10] = '{MEM_OP_LW,  32'h10, 32'h0,        0, 32'h11AB3344, 3, 32'h0,        1'b0, 1'b0};
    tbl[11] = '{MEM_OP_SH,  32'h13, 32'h00001234, 0, 32'h0,        1, 32'h0,        1'b0, 1'b1};
    tbl[12] = '{MEM_OP_LW,  32'h12, 32'h0,        0, 32'h0,        1, 32'h0,        1'b1, 1'b0};
    tbl[13] = '{MEM_OP_SH,  32'h22, 32'h5555BEEF, 2, 32'h0,        5, 32'h80FFBEEF, 1'b0, 1'b0};
    tbl[14] = '{MEM_OP_LW,  32'h20, 32'h0,        0, 32'h80FFBEEF, 3, 32'h0,        1'b0, 1'b0};
    tbl[15] = '{MEM_OP_LBU, 32'h23, 32'h0,        0, 32'h000000EF, 3, 32'h0,        1'b0, 1'b0};
    tbl[16] = '{MEM_OP_LB,  32'h21, 32'h0,        0, 32'hFFFFFFFF, 3, 32'h0,        1'b0, 1'b0};

    @(negedge clk);
    @(negedge clk);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_exc_bad", bad_addr_o | {30'h0, exc_adel_o, exc_ades_o}, 32'h0);
    chk("rst_ram_ctl", {30'h0, ram_ce_o, ram_we_o}, 32'h0);
    chk("rst_ram_bus", ram_addr_o | ram_data_o, 32'h0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].hold, lat, rd, wr, bad, adel, ades, saw_ce, stall_ok, stable, idle_clr);
      mis = tbl[i].exp_adel || tbl[i].exp_ades;
      chk($sformatf("v%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("v%0d_exc", i), {30'h0, adel, ades}, {30'h0, tbl[i].exp_adel, tbl[i].exp_ades});
      chk($sformatf("v%0d_bad", i), bad, mis ? tbl[i].addr : 32'h0);
      chk($sformatf("v%0d_ce", i), {31'h0, saw_ce}, {31'h0, !mis});
      chk($sformatf("v%0d_stall", i), {31'h0, stall_ok}, 32'h1);
      chk($sformatf("v%0d_stable", i), {31'h0, stable}, 32'h1);
      chk($sformatf("v%0d_idle", i), {31'h0, idle_clr}, 32'h1);
      if (is_st(tbl[i].op) && !mis) begin
        chk($sformatf("v%0d_wr", i), wr, tbl[i].exp_wr);
        ref_mem[tbl[i].addr[7:2]] = m_store(tbl[i].op, ref_mem[tbl[i].addr[7:2]], tbl[i].addr, tbl[i].wdata);
      end
    end

    // Undefined op codes and op 0 never stall or touch the RAM.
    req_i = 1'b1; op_i = 4'd9; addr_i = 32'h10;
    #1 chk("inv9_stall", {31'h0, stall_o}, 32'h0);
    @(negedge clk);
    chk("inv9_idle", {29'h0, ram_ce_o, stall_o, done_o}, 32'h0);
    op_i = 4'hF;
    #1 chk("invF_stall", {31'h0, stall_o}, 32'h0);
    op_i = 4'd0;
    #1 chk("op0_stall", {31'h0, stall_o}, 32'h0);
    req_i = 1'b0;
    @(negedge clk);

    // req held high: request seen in DONE is ignored, next access restarts from IDLE.
    req_i = 1'b1; op_i = MEM_OP_LW; addr_i = 32'h10;
    done_seen = 8'h0;
    for (int k = 0; k < 8; k++) begin
      #1 done_seen[k] = done_o;
      @(negedge clk);
    end
    req_i = 1'b0; op_i = 4'd0;
    chk("b2b_done_pattern", {24'h0, done_seen}, 32'h00000088);
    @(negedge clk);

    // Reset dropped while the store sits in WR_DATA.
    hold_req = 5;
    req_i = 1'b1; op_i = MEM_OP_SW; addr_i = 32'h10; wdata_i = 32'hDEADBEEF;
    @(negedge clk);
    req_i = 1'b0; op_i = 4'd0;
    @(negedge clk);
    chk("mid_we_pre", {30'h0, ram_ce_o, ram_we_o}, 32'h3);
    rst = 1'b0;
    #1;
    chk("mid_ctl", {27'h0, stall_o, done_o, ram_ce_o, ram_we_o, exc_adel_o | exc_ades_o}, 32'h0);
    chk("mid_bus", ram_addr_o | ram_data_o | rdata_o | bad_addr_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    hold_req = 0;
    run_op(MEM_OP_LW, 32'h10, 32'h0, 0, lat, rd, wr, bad, adel, ades, saw_ce, stall_ok, stable, idle_clr);
    chk("mid_post_lw", rd, 32'h11AB3344);
    chk("mid_post_lat", lat, 3);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      logic [31:0] a, wd;
      int hold;
      op = 4'($urandom_range(1, 8));
      a = $urandom_range(0, 63);
      wd = $urandom;
      hold = $urandom_range(0, 2);
      mis = m_mis(op, a);
      st = is_st(op);
      exp_rd = (mis || st) ? 32'h0 : m_load(op, ref_mem[a[7:2]], a);
      run_op(op, a, wd, hold, lat, rd, wr, bad, adel, ades, saw_ce, stall_ok, stable, idle_clr);
      chk($sformatf("r%0d_lat", i), lat, mis ? 1 : (st ? 3 + hold : 3));
      chk($sformatf("r%0d_rdata", i), rd, exp_rd);
      chk($sformatf("r%0d_exc", i), {30'h0, adel, ades}, {30'h0, mis && !st, mis && st});
      chk($sformatf("r%0d_bad", i), bad, mis ? a : 32'h0);
      chk($sformatf("r%0d_flow", i), {29'h0, saw_ce, stall_ok, idle_clr}, {29'h0, !mis, 1'b1, 1'b1});
      if (st && !mis) begin
        chk($sformatf("r%0d_wr", i), wr, m_store(op, ref_mem[a[7:2]], a, wd));
        ref_mem[a[7:2]] = m_store(op, ref_mem[a[7:2]], a, wd);
      end
    end

    bad_words = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad_words++;
    chk("ram_image", bad_words, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store sequencer sitting directly upstream of the data RAM; issues ce/we/addr/data to it and consumes its read data and ack.
- The RAM is word-only (32-bit, no byte enables), so this block performs byte/halfword extraction on loads and read-modify-write on sub-word stores.
- Holds the pipeline with stall_o for the duration of each access and flags address-error exceptions.
- Byte order is big-endian: addr[1:0]=0 selects bits 31:24.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width (only 32 supported)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_i  in  1  MEM-stage instruction is a memory op this cycle
- op_i  in  4  memory op code (LB, LBU, LH, LHU, LW, SB, SH, SW; 0 = none)
- addr_i  in  32  effective byte address
- wdata_i  in  32  store data (low-order bits used for SB/SH)
- stall_o  out  1  hold pipeline
- done_o  out  1  one-cycle pulse: access finished or faulted
- rdata_o  out  32  load result, extended, valid while done_o=1
- exc_adel_o  out  1  misaligned load, valid with done_o
- exc_ades_o  out  1  misaligned store, valid with done_o
- bad_addr_o  out  32  faulting address, valid with done_o
- ram_ce_o  out  1  RAM chip enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  32  RAM address, word-aligned (bits 1:0 forced 0)
- ram_data_o  out  32  RAM write data
- ram_data_i  in  32  RAM read data, registered in RAM, valid the cycle after ce
- ram_ack_i  in  1  RAM ack; low while a write is pending

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0: stall_o, done_o, rdata_o, exception flags, bad_addr_o, ram_ce_o, ram_we_o, ram_addr_o, ram_data_o.
- Request capture: on the IDLE edge with req_i=1 and op_i!=0, latch op, addr and wdata. ram_* outputs are driven from the latched copies only.
- States: IDLE, ISSUE, RD_WAIT, WR_DATA, DONE.
- IDLE:
  - req_i=0 or op_i=0: stay in IDLE, stall_o=0.
  - Valid req: stall_o=1 combinationally.
  - Misaligned (halfword with addr[0]=1, word with addr[1:0]!=0): go to DONE with the exception flag set. No RAM access occurs.
  - Otherwise: go to ISSUE.
- ISSUE: ram_ce_o=1, ram_addr_o = latched addr with bits 1:0 = 0, ram_we_o=1 for stores. Next state: RD_WAIT for loads, WR_DATA for stores.
- RD_WAIT (load): ram_ce_o=0. Extract the lane from ram_data_i:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: whole word.
  - Register the result into rdata_o, then go to DONE.
- WR_DATA (store):
  - ram_ce_o=1, ram_we_o=1, same address.
  - ram_data_o = ram_data_i (old word) with the addressed lane(s) replaced by wdata bits 7:0 (SB) or 15:0 (SH). SW uses wdata whole.
  - Go to DONE only when ram_ack_i=1; otherwise hold.
- DONE: done_o=1, stall_o=0, ram_ce_o=0, ram_we_o=0. Next state IDLE. Exception flags and rdata_o return to 0 in IDLE.
- Latency from request cycle to done_o:
  - Load: 3 cycles (done in cycle 3).
  - Store: 3 cycles minimum (done in cycle 3), plus one extra cycle per cycle of ram_ack_i=0 held in WR_DATA.
  - Misaligned: 1 cycle.
- stall_o is 1 in ISSUE, RD_WAIT and WR_DATA. It is 0 in DONE so the pipeline advances on that edge.
- req_i seen in DONE is ignored. A back-to-back request starts from IDLE on the next cycle.
- In ISSUE for a store, ram_ack_i=0 is expected; it is not checked.
- Reset mid-access: immediately abandon the access and drop ram_we_o. System reset must also reset the RAM so no half-written word survives.
- op_i values outside the defined set are treated as 0 (no access, no stall).

Decomposition:
- Shared defines file holds:
  - MEM_OP_* codes (4-bit): NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8.
  - State encodings.
  - Reset-active level for the active-low reset.
- One sub-module, mem_lane_align: purely combinational; given op, addr[1:0], old word and store data, produces the extended load value and the merged store word. Reusable by a future cache.

Test Plan:
- LW: RAM word at 0x10 = 0x11223344, LW 0x10 -> ram_ce_o=1 in cycle 1, done_o in cycle 3, rdata_o=0x11223344, stall_o=1 in cycles 0-2.
- LB/LBU: same word, addr 0x13 holds 0x44; word at 0x20 = 0x80FF0000, LB 0x20 -> 0xFFFFFF80, LBU 0x20 -> 0x00000080.
- SB RMW: word 0x11223344 at 0x10, SB 0x11 with wdata 0xAB -> the WR_DATA write is 0x11AB3344; a following LW reads 0x11AB3344.
- Misaligned: SH 0x13 -> done_o after 1 cycle, exc_ades_o=1, bad_addr_o=0x13, ram_ce_o never asserted. LW 0x12 -> exc_adel_o=1.
- Ack hold: force ram_ack_i=0 for 2 extra cycles in WR_DATA -> stall_o stays 1, done_o delayed by 2, ram_data_o stable.
- Reset mid-store: drop rst in WR_DATA -> all outputs 0 immediately. After release, an LW of the same word returns its pre-store value.
